// File: rtl/alu_div_pkg.sv
// Shared definitions for the execute-stage multiply/divide units:
// funct codes, divider FSM encodings and the datapath width.
package alu_div_pkg;

  localparam int XLEN = 32;
  localparam int CNT_W = 5;

  // MUL group
  localparam logic [4:0] FUNCT_MUL    = 5'b01110;
  localparam logic [4:0] FUNCT_MULH   = 5'b01111;
  localparam logic [4:0] FUNCT_MULHSU = 5'b10000;
  localparam logic [4:0] FUNCT_MULHU  = 5'b10001;

  // DIV group
  localparam logic [4:0] FUNCT_DIV  = 5'b10010;
  localparam logic [4:0] FUNCT_DIVU = 5'b10011;
  localparam logic [4:0] FUNCT_REM  = 5'b10100;
  localparam logic [4:0] FUNCT_REMU = 5'b10101;

  typedef enum logic [3:0] {
    S_IDLE = 4'b0001,
    S_INI  = 4'b0010,
    S_RUN  = 4'b0100,
    S_DONE = 4'b1000
  } div_state_e;

endpackage

// File: rtl/alu_div_step.sv
// One restoring division step: shift in the next dividend bit, trial-subtract
// the divisor, keep the difference when it did not go negative.
module alu_div_step
  import alu_div_pkg::*;
(
  input  logic [XLEN-1:0] rem_i,
  input  logic            dvd_msb_i,
  input  logic [XLEN-1:0] dvs_i,
  output logic [XLEN-1:0] rem_o,
  output logic            q_bit_o
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] trial;

  // rem < dvs always holds, so the 33-bit difference never wraps and its
  // MSB is a valid sign bit.
  always_comb begin
    shifted = {rem_i, dvd_msb_i};
    trial   = shifted - {1'b0, dvs_i};
    q_bit_o = ~trial[XLEN];
    rem_o   = q_bit_o ? trial[XLEN-1:0] : shifted[XLEN-1:0];
  end

endmodule

// File: rtl/alu_div.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU with the same
// strobe/done handshake as the multiplier.
module alu_div
  import alu_div_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            alu_div_stb_i,
  input  logic [4:0]      alu_div_funct_i,
  input  logic [XLEN-1:0] alu_div_op1_i,
  input  logic [XLEN-1:0] alu_div_op2_i,
  output logic            alu_div_done_o,
  output logic [XLEN-1:0] alu_div_res_o
);

  div_state_e state_q, state_d;
  logic [4:0]      funct_q, funct_d;
  logic [XLEN-1:0] dvd_q, dvd_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic q_neg_q, q_neg_d;
  logic r_neg_q, r_neg_d;
  logic special_q, special_d;
  logic fix_q, fix_d;
  logic done_q, done_d;
  logic [XLEN-1:0] res_q, res_d;

  logic            is_signed;
  logic            is_rem;
  logic [XLEN-1:0] step_rem;
  logic            step_q_bit;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  // Unknown funct codes fall through as DIVU: unsigned, quotient result.
  assign is_signed = (funct_q == FUNCT_DIV) || (funct_q == FUNCT_REM);
  assign is_rem    = (funct_q == FUNCT_REM) || (funct_q == FUNCT_REMU);

  alu_div_step u_step (
    .rem_i     (rem_q),
    .dvd_msb_i (dvd_q[XLEN-1]),
    .dvs_i     (dvs_q),
    .rem_o     (step_rem),
    .q_bit_o   (step_q_bit)
  );

  // NOTE: every _d gets a default at the top so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    funct_d   = funct_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    cnt_d     = cnt_q;
    q_neg_d   = q_neg_q;
    r_neg_d   = r_neg_q;
    special_d = special_q;
    fix_d     = fix_q;
    done_d    = done_q;
    res_d     = res_q;

    unique case (state_q)
      S_IDLE: begin
        done_d = 1'b0;
        if (alu_div_stb_i) begin
          funct_d = alu_div_funct_i;
          dvd_d   = alu_div_op1_i;
          dvs_d   = alu_div_op2_i;
          state_d = S_INI;
        end
      end

      S_INI: begin
        fix_d     = 1'b0;
        special_d = 1'b0;
        q_neg_d   = 1'b0;
        r_neg_d   = 1'b0;
        if (dvs_q == '0) begin
          quo_d     = '1;
          rem_d     = dvd_q;
          special_d = 1'b1;
          state_d   = S_DONE;
        end else if (is_signed && dvd_q == INT_MIN && dvs_q == '1) begin
          quo_d     = INT_MIN;
          rem_d     = '0;
          special_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          dvd_d   = (is_signed && dvd_q[XLEN-1]) ? -dvd_q : dvd_q;
          dvs_d   = (is_signed && dvs_q[XLEN-1]) ? -dvs_q : dvs_q;
          q_neg_d = is_signed && (dvd_q[XLEN-1] ^ dvs_q[XLEN-1]);
          r_neg_d = is_signed && dvd_q[XLEN-1];
          rem_d   = '0;
          quo_d   = '0;
          cnt_d   = CNT_W'(XLEN - 1);
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        rem_d = step_rem;
        quo_d = {quo_q[XLEN-2:0], step_q_bit};
        dvd_d = {dvd_q[XLEN-2:0], 1'b0};
        if (cnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_DONE: begin
        // First DONE cycle applies the sign fix-up, second publishes the result.
        if (!fix_q) begin
          fix_d = 1'b1;
          if (!special_q) begin
            quo_d = q_neg_q ? -quo_q : quo_q;
            rem_d = r_neg_q ? -rem_q : rem_q;
          end
        end else begin
          fix_d   = 1'b0;
          res_d   = is_rem ? rem_q : quo_q;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      funct_q   <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      cnt_q     <= '0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      special_q <= 1'b0;
      fix_q     <= 1'b0;
      done_q    <= 1'b0;
      res_q     <= '0;
    end else begin
      state_q   <= state_d;
      funct_q   <= funct_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      cnt_q     <= cnt_d;
      q_neg_q   <= q_neg_d;
      r_neg_q   <= r_neg_d;
      special_q <= special_d;
      fix_q     <= fix_d;
      done_q    <= done_d;
      res_q     <= res_d;
    end
  end

  assign alu_div_done_o = done_q;
  assign alu_div_res_o  = res_q;

endmodule

// File: tb/tb_alu_div.sv
// Self-checking bench for alu_div: directed table, randomized ops against an
// arithmetic reference, back-to-back issue with a held strobe, and mid-run reset.
module tb_alu_div;

  localparam logic [4:0] F_DIV  = 5'b10010;
  localparam logic [4:0] F_DIVU = 5'b10011;
  localparam logic [4:0] F_REM  = 5'b10100;
  localparam logic [4:0] F_REMU = 5'b10101;
  localparam int LAT_NORMAL  = 35;
  localparam int LAT_SPECIAL = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stb = 1'b0;
  logic [4:0]  funct = '0;
  logic [31:0] op1 = '0;
  logic [31:0] op2 = '0;
  logic        done;
  logic [31:0] res;

  int n_checks = 0;
  int n_fail   = 0;

  alu_div dut (
    .clk             (clk),
    .reset           (reset),
    .alu_div_stb_i   (stb),
    .alu_div_funct_i (funct),
    .alu_div_op1_i   (op1),
    .alu_div_op2_i   (op2),
    .alu_div_done_o  (done),
    .alu_div_res_o   (res)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       name;
    logic [4:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // RISC-V M semantics written directly with integer arithmetic.
  function automatic logic [31:0] ref_div(input logic [4:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
    bit sgn = (f == F_DIV) || (f == F_REM);
    bit want_rem = (f == F_REM) || (f == F_REMU);
    logic [31:0] q, r;
    int sa, sb;
    if (b == 0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 0;
    end else if (sgn) begin
      sa = a;
      sb = b;
      q = sa / sb;
      r = sa % sb;
    end else begin
      q = a / b;
      r = a % b;
    end
    return want_rem ? r : q;
  endfunction

  function automatic int ref_lat(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b);
    bit sgn = (f == F_DIV) || (f == F_REM);
    if (b == 0 || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return LAT_SPECIAL;
    return LAT_NORMAL;
  endfunction

  // Issue one op from IDLE; measure edges from the accepting edge to done.
  task automatic run_op(input string name, input logic [4:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat;
    @(negedge clk);
    stb = 1'b1;
    funct = f;
    op1 = a;
    op2 = b;
    @(posedge clk);
    @(negedge clk);
    stb = 1'b0;
    funct = 5'($urandom);
    op1 = $urandom;
    op2 = $urandom;
    lat = 0;
    while (lat <= 60) begin
      @(negedge clk);
      lat++;
      if (done) break;
    end
    check({name, " latency"}, 32'(lat), 32'(exp_lat));
    check({name, " result"}, res, exp);
    @(negedge clk);
    check({name, " done drop"}, {31'b0, done}, 32'd0);
  endtask

  vec_t vecs[$];
  logic [4:0]  hf[0:127];
  logic [31:0] ha[0:127];
  logic [31:0] hb[0:127];

  initial begin
    vecs.push_back('{"div 20/-3",      F_DIV,  32'd20,         32'hFFFF_FFFD, 32'hFFFF_FFFA, LAT_NORMAL});
    vecs.push_back('{"rem 20/-3",      F_REM,  32'd20,         32'hFFFF_FFFD, 32'd2,         LAT_NORMAL});
    vecs.push_back('{"divu max/2",     F_DIVU, 32'hFFFF_FFFF,  32'd2,         32'h7FFF_FFFF, LAT_NORMAL});
    vecs.push_back('{"remu max/2",     F_REMU, 32'hFFFF_FFFF,  32'd2,         32'd1,         LAT_NORMAL});
    vecs.push_back('{"rem -7/2",       F_REM,  32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, LAT_NORMAL});
    vecs.push_back('{"div 5/0",        F_DIV,  32'd5,          32'd0,         32'hFFFF_FFFF, LAT_SPECIAL});
    vecs.push_back('{"remu 5/0",       F_REMU, 32'd5,          32'd0,         32'd5,         LAT_SPECIAL});
    vecs.push_back('{"div ovf",        F_DIV,  32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, LAT_SPECIAL});
    vecs.push_back('{"rem ovf",        F_REM,  32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         LAT_SPECIAL});
    vecs.push_back('{"divu min/-1",    F_DIVU, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         LAT_NORMAL});
    vecs.push_back('{"div -20/3",      F_DIV,  32'hFFFF_FFEC,  32'd3,         32'hFFFF_FFFA, LAT_NORMAL});
    vecs.push_back('{"rem -20/-3",     F_REM,  32'hFFFF_FFEC,  32'hFFFF_FFFD, 32'hFFFF_FFFE, LAT_NORMAL});
    vecs.push_back('{"unknown 100/7",  5'b00000, 32'd100,      32'd7,         32'd14,        LAT_NORMAL});

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("reset done", {31'b0, done}, 32'd0);
    check("reset res", res, 32'd0);

    foreach (vecs[i])
      run_op(vecs[i].name, vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

    // Random ops against the arithmetic reference, including special cases.
    for (int i = 0; i < 30; i++) begin
      logic [4:0]  f;
      logic [31:0] a, b;
      case ($urandom_range(0, 4))
        0: f = F_DIV;
        1: f = F_DIVU;
        2: f = F_REM;
        3: f = F_REMU;
        default: f = 5'($urandom);
      endcase
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 7) == 0) b = 0;
      if ($urandom_range(0, 9) == 0) begin
        a = 32'h8000_0000;
        b = 32'hFFFF_FFFF;
      end
      run_op("random", f, a, b, ref_div(f, a, b), ref_lat(f, a, b));
    end

    // Strobe held high, operands changing every cycle: accepts at edges 0, 36, 72.
    @(negedge clk);
    for (int e = 0; e < 108; e++) begin
      logic [31:0] b;
      case ($urandom_range(0, 3))
        0: hf[e] = F_DIV;
        1: hf[e] = F_DIVU;
        2: hf[e] = F_REM;
        default: hf[e] = F_REMU;
      endcase
      ha[e] = $urandom;
      b = $urandom >> $urandom_range(0, 28);
      if (b == 0 || b == 32'hFFFF_FFFF) b = 32'd9;
      hb[e] = b;
      stb = 1'b1;
      funct = hf[e];
      op1 = ha[e];
      op2 = hb[e];
      @(posedge clk);
      @(negedge clk);
      if (e == 35 || e == 71 || e == 107) begin
        check("b2b done", {31'b0, done}, 32'd1);
        check("b2b result", res, ref_div(hf[e-35], ha[e-35], hb[e-35]));
      end else if (done) begin
        check("b2b stray done", {31'b0, done}, 32'd0);
      end
    end
    stb = 1'b0;

    // Reset during RUN aborts the op with no done pulse and clears the result.
    @(negedge clk);
    stb = 1'b1;
    funct = F_DIV;
    op1 = 32'd1000;
    op2 = 32'd3;
    @(posedge clk);
    @(negedge clk);
    stb = 1'b0;
    repeat (11) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort done", {31'b0, done}, 32'd0);
    check("abort res", res, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    begin
      int pulses = 0;
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        if (done) pulses++;
      end
      check("abort no pulse", 32'(pulses), 32'd0);
    end
    check("abort res held", res, 32'd0);
    run_op("post-reset divu 100/7", F_DIVU, 32'd100, 32'd7, 32'd14, LAT_NORMAL);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
